aes128_rijndael_sbox: RTL and testbench

AES128_RIJNDAEL_SBOX -- requirements
Module: aes128_rijndael_sbox

---
 rtl/aes128_pkg.sv | 77 +++++++
 rtl/aes128_rijndael_sbox.sv | 56 +++++
 tb/tb_aes128_rijndael_sbox.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/aes128_pkg.sv
// AES-128 byte substitution tables shared by the S-box block.
// INV_SBOX is referenced only when AES128_SBOX_INV_EN is defined.
package aes128_pkg;

  typedef logic [7:0] aes_byte_t;

  localparam aes_byte_t SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam aes_byte_t INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes128_rijndael_sbox.sv
// AES S-box: combinational lookup plus one optional registered stage.
// Define AES128_SBOX_INV_EN to add inv_i and the inverse table.
module aes128_rijndael_sbox
  import aes128_pkg::*;
#(
  parameter aes_byte_t RST_VAL = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
`ifdef AES128_SBOX_INV_EN
  input  logic       inv_i,
`endif
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [7:0] data_o,
  output logic [7:0] data_q_o,
  output logic       valid_q_o
);

  aes_byte_t sub;
  aes_byte_t data_d, data_q;
  logic      valid_d, valid_q;

`ifdef AES128_SBOX_INV_EN
  always_comb begin
    sub = SBOX[data_i];
    if (inv_i) sub = INV_SBOX[data_i];
  end
`else
  always_comb begin
    sub = SBOX[data_i];
  end
`endif

  // Captured byte holds across idle cycles; valid follows every cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_i;
    if (valid_i) data_d = sub;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q  <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o    = sub;
  assign data_q_o  = data_q;
  assign valid_q_o = valid_q;

endmodule

// File: tb/tb_aes128_rijndael_sbox.sv
// Bench for aes128_rijndael_sbox: vector table, GF(2^8) reference
// sweep and a scoreboard for the registered stage.
module tb_aes128_rijndael_sbox;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inv = 1'b0;
  logic [7:0] din = 8'h00;
  logic       vin = 1'b0;
  logic [7:0] dout, dq, dq_a5, dout_a5;
  logic       vq, vq_a5;

  always #5 clk = ~clk;

  aes128_rijndael_sbox dut (
    .clk_i(clk), .rst_n_i(rst_n),
`ifdef AES128_SBOX_INV_EN
    .inv_i(inv),
`endif
    .data_i(din), .valid_i(vin),
    .data_o(dout), .data_q_o(dq), .valid_q_o(vq)
  );

  aes128_rijndael_sbox #(.RST_VAL(8'hA5)) dut_a5 (
    .clk_i(clk), .rst_n_i(rst_n),
`ifdef AES128_SBOX_INV_EN
    .inv_i(inv),
`endif
    .data_i(din), .valid_i(vin),
    .data_o(dout_a5), .data_q_o(dq_a5), .valid_q_o(vq_a5)
  );

  typedef struct { logic [7:0] din; logic [7:0] dout; } vec_t;
  typedef struct { logic v; logic [7:0] d; logic [7:0] da5; } exp_t;

  vec_t       fwd_vec [6];
  exp_t       sbq [$];
  logic [7:0] ref_tab [256];
  logic [7:0] m_d, m_a5;
  logic       m_v;
  int         pass_cnt = 0;
  int         chk_cnt = 0;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h want %02h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] iv = 8'h00;
    logic [7:0] s;
    for (int b = 1; b < 256; b++)
      if (x != 8'h00 && gmul(x, 8'(b)) == 8'h01) iv = 8'(b);
    s = iv ^ 8'h63;
    for (int k = 1; k < 5; k++)
      s ^= 8'((iv << k) | (iv >> (8 - k)));
    return s;
  endfunction

  // Drive one cycle, predict the post-edge state, compare after the edge.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d);
    exp_t e;
    rst_n = r; vin = v; din = d;
    if (!r) begin
      m_d = 8'h00; m_a5 = 8'hA5; m_v = 1'b0;
    end else begin
      m_v = v;
      if (v) begin m_d = ref_tab[d]; m_a5 = ref_tab[d]; end
    end
    sbq.push_back('{m_v, m_d, m_a5});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk_cnt++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = sbq.pop_front();
      check("valid_q", {7'd0, vq}, {7'd0, e.v});
      check("data_q", dq, e.d);
      check("data_q_a5", dq_a5, e.da5);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] seen;
    int dups;
    fwd_vec[0] = '{8'h00, 8'h63};
    fwd_vec[1] = '{8'h01, 8'h7C};
    fwd_vec[2] = '{8'h53, 8'hED};
    fwd_vec[3] = '{8'h10, 8'hCA};
    fwd_vec[4] = '{8'hC9, 8'hDD};
    fwd_vec[5] = '{8'hFF, 8'h16};
    for (int i = 0; i < 256; i++) ref_tab[i] = ref_sbox(8'(i));

    // Combinational checks run with reset held low.
    for (int i = 0; i < 6; i++) begin
      din = fwd_vec[i].din;
      #1;
      check("comb_vec", dout, fwd_vec[i].dout);
    end

    seen = '0;
    dups = 0;
    for (int i = 0; i < 256; i++) begin
      din = 8'(i);
      #1;
      check("sweep", dout, ref_tab[i]);
      if (seen[dout]) dups++;
      seen[dout] = 1'b1;
    end
    chk_cnt++;
    if (dups == 0) pass_cnt++;
    else $display("FAIL distinct: got %0d dups want 0", dups);

`ifdef AES128_SBOX_INV_EN
    begin
      vec_t inv_vec [4];
      logic [7:0] f;
      inv_vec[0] = '{8'h63, 8'h00};
      inv_vec[1] = '{8'hED, 8'h53};
      inv_vec[2] = '{8'h16, 8'hFF};
      inv_vec[3] = '{8'h00, 8'h52};
      inv = 1'b1;
      for (int i = 0; i < 4; i++) begin
        din = inv_vec[i].din;
        #1;
        check("inv_vec", dout, inv_vec[i].dout);
      end
      for (int i = 0; i < 256; i++) begin
        inv = 1'b0; din = 8'(i);
        #1;
        f = dout;
        inv = 1'b1; din = f;
        #1;
        check("round_trip", dout, 8'(i));
      end
      inv = 1'b0;
    end
`endif

    @(negedge clk);
    m_d = 8'h00; m_a5 = 8'hA5; m_v = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check("rst_data", dq, 8'h00);
    check("rst_valid", {7'd0, vq}, 8'h00);
    check("rst_data_a5", dq_a5, 8'hA5);

    cyc(1'b1, 1'b1, 8'h53);
    check("edge_n_data", dq, 8'hED);
    check("edge_n_valid", {7'd0, vq}, 8'h01);
    cyc(1'b1, 1'b0, 8'h00);
    check("hold_data", dq, 8'hED);
    check("hold_valid", {7'd0, vq}, 8'h00);

    cyc(1'b0, 1'b1, 8'h01);
    check("rst_prio_data", dq, 8'h00);
    check("rst_prio_a5", dq_a5, 8'hA5);
    check("rst_prio_valid", {7'd0, vq}, 8'h00);

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 8'(i * 37));
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
